// File: rtl/demux1to4_buf_if.sv
// Bus bundle for demux1to4_buf: the input word/select handshake, the per-channel
// read strobes, and the four holding registers with their full flags.
interface demux1to4_buf_if #(
    parameter int WIDTH = 3
) ();
    logic [WIDTH-1:0] w;
    logic [1:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       rd;
    logic [WIDTH-1:0] f0;
    logic [WIDTH-1:0] f1;
    logic [WIDTH-1:0] f2;
    logic [WIDTH-1:0] f3;
    logic [3:0]       full;

    // Source and consumers side.
    modport master (
        output w, s, in_valid, rd,
        input  in_ready, f0, f1, f2, f3, full
    );

    // Demultiplexer side.
    modport slave (
        input  w, s, in_valid, rd,
        output in_ready, f0, f1, f2, f3, full
    );
endinterface

// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 demultiplexer with a one-word buffer per channel.
// Define DEMUX_AUTO_SEL_EN to pick channels round-robin instead of from s.
module demux1to4_buf #(
    parameter int WIDTH = 3
) (
    input logic              clk,
    input logic              rst,
    demux1to4_buf_if.slave   bus
);
    logic [1:0]       sel;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] f_reg [4];
    logic [3:0]       full_reg;
    logic [3:0]       full_next;
    logic [3:0]       wr_en;

`ifdef DEMUX_AUTO_SEL_EN
    logic [1:0] cnt_reg;

    // Pointer only moves on an accepted word, so a stall keeps waiting on the same channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 2'd0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 2'd1;
        end
    end

    assign sel = cnt_reg;
`else
    assign sel = bus.s;
`endif

    // A read in the same cycle frees the slot, allowing one word per cycle per channel.
    assign in_ready = !full_reg[sel] || bus.rd[sel];
    assign accept   = bus.in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            assign wr_en[gi]     = accept && (sel == 2'(gi));
            assign full_next[gi] = wr_en[gi] ? 1'b1 :
                                   (bus.rd[gi] ? 1'b0 : full_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                f_reg[i] <= '0;
            end
        end else begin
            full_reg <= full_next;
            for (int i = 0; i < 4; i++) begin
                if (wr_en[i]) begin
                    f_reg[i] <= bus.w;
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.f0       = f_reg[0];
    assign bus.f1       = f_reg[1];
    assign bus.f2       = f_reg[2];
    assign bus.f3       = f_reg[3];
    assign bus.full     = full_reg;
endmodule

// File: tb/tb_demux1to4_buf.sv
// Directed scoreboard bench for demux1to4_buf: each vector queues its hand-computed
// in_ready and post-edge register state; a separate monitor pops and compares.
module tb_demux1to4_buf;
    localparam int WIDTH = 3;

    logic clk;
    logic rst;

    demux1to4_buf_if #(.WIDTH(WIDTH)) bus ();

    demux1to4_buf #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] s;
        logic [2:0] w;
        logic [3:0] rd;
        bit         chk_rdy;
        logic       rdy;
        logic [2:0] f0;
        logic [2:0] f1;
        logic [2:0] f2;
        logic [2:0] f3;
        logic [3:0] full;
        int         idx;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic v, input logic [1:0] s, input logic [2:0] w,
                       input logic [3:0] rd, input bit chk_rdy, input logic rdy,
                       input logic [2:0] f0, input logic [2:0] f1, input logic [2:0] f2,
                       input logic [2:0] f3, input logic [3:0] full);
        vec_t e;
        e.rst = r; e.v = v; e.s = s; e.w = w; e.rd = rd;
        e.chk_rdy = chk_rdy; e.rdy = rdy;
        e.f0 = f0; e.f1 = f1; e.f2 = f2; e.f3 = f3; e.full = full;
        e.idx = vecs.size();
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %b expected %b", idx, name, act, exp);
        end
    endtask

    // Monitor: in_ready just before the edge, registered outputs just after it.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_rdy) chk("in_ready", e.idx, {3'b000, bus.in_ready}, {3'b000, e.rdy});
                @(posedge clk);
                #1;
                chk("f0", e.idx, {1'b0, bus.f0}, {1'b0, e.f0});
                chk("f1", e.idx, {1'b0, bus.f1}, {1'b0, e.f1});
                chk("f2", e.idx, {1'b0, bus.f2}, {1'b0, e.f2});
                chk("f3", e.idx, {1'b0, bus.f3}, {1'b0, e.f3});
                chk("full", e.idx, bus.full, e.full);
                $display("vec%0d rst=%b v=%b s=%0d w=%0d rd=%b -> rdy=%b f=%0d,%0d,%0d,%0d full=%b",
                         e.idx, e.rst, e.v, e.s, e.w, e.rd, bus.in_ready,
                         bus.f0, bus.f1, bus.f2, bus.f3, bus.full);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.w = '0; bus.s = 2'd0; bus.in_valid = 1'b0; bus.rd = 4'b0000;

        //   rst v  s  w  rd      chk rdy  f0 f1 f2 f3 full
        add(1, 0, 0, 0, 4'b0000, 0, 0,   0, 0, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 4'b0000, 1, 1,   0, 0, 0, 0, 4'b0000);
`ifdef DEMUX_AUTO_SEL_EN
        // Round-robin stream with every channel drained each cycle; s is ignored.
        add(0, 1, 3, 1, 4'b1111, 1, 1,   1, 0, 0, 0, 4'b0001);
        add(0, 1, 3, 2, 4'b1111, 1, 1,   1, 2, 0, 0, 4'b0010);
        add(0, 1, 3, 3, 4'b1111, 1, 1,   1, 2, 3, 0, 4'b0100);
        add(0, 1, 3, 4, 4'b1111, 1, 1,   1, 2, 3, 4, 4'b1000);
        add(0, 1, 3, 5, 4'b1111, 1, 1,   5, 2, 3, 4, 4'b0001);
        // Fill channels 1..3 so the pointer wraps back to a full channel 0.
        add(0, 1, 3, 6, 4'b0000, 1, 1,   5, 6, 3, 4, 4'b0011);
        add(0, 1, 3, 7, 4'b0000, 1, 1,   5, 6, 7, 4, 4'b0111);
        add(0, 1, 3, 1, 4'b0000, 1, 1,   5, 6, 7, 1, 4'b1111);
        add(0, 1, 3, 2, 4'b0000, 1, 0,   5, 6, 7, 1, 4'b1111);
        add(0, 1, 3, 2, 4'b0000, 1, 0,   5, 6, 7, 1, 4'b1111);
        add(0, 1, 3, 2, 4'b0000, 1, 0,   5, 6, 7, 1, 4'b1111);
        add(0, 1, 3, 2, 4'b0001, 1, 1,   2, 6, 7, 1, 4'b1111);
        // Pointer must now be at channel 1.
        add(0, 1, 3, 3, 4'b0010, 1, 1,   2, 3, 7, 1, 4'b1111);
        add(0, 0, 3, 0, 4'b0000, 1, 0,   2, 3, 7, 1, 4'b1111);
`else
        add(0, 1, 0, 1, 4'b0000, 1, 1,   1, 0, 0, 0, 4'b0001);
        add(0, 1, 1, 2, 4'b0000, 1, 1,   1, 2, 0, 0, 4'b0011);
        add(0, 1, 2, 3, 4'b0000, 1, 1,   1, 2, 3, 0, 4'b0111);
        add(0, 1, 3, 4, 4'b0000, 1, 1,   1, 2, 3, 4, 4'b1111);
        // Back-pressure, then read-then-write on the same edge.
        add(0, 1, 2, 5, 4'b0000, 1, 0,   1, 2, 3, 4, 4'b1111);
        add(0, 1, 2, 5, 4'b0100, 1, 1,   1, 2, 5, 4, 4'b1111);
        // Read without write, and a repeated read of an empty channel.
        add(0, 0, 0, 0, 4'b0001, 1, 1,   1, 2, 5, 4, 4'b1110);
        add(0, 0, 0, 0, 4'b0001, 1, 1,   1, 2, 5, 4, 4'b1110);
        add(0, 0, 1, 0, 4'b0110, 1, 1,   1, 2, 5, 4, 4'b1000);
        add(0, 1, 0, 6, 4'b0000, 1, 1,   6, 2, 5, 4, 4'b1001);
        add(0, 1, 1, 1, 4'b0000, 1, 1,   6, 1, 5, 4, 4'b1011);
        // Reset beats a simultaneous accept.
        add(1, 1, 2, 7, 4'b0000, 1, 1,   0, 0, 0, 0, 4'b0000);
        add(0, 0, 2, 7, 4'b0000, 1, 1,   0, 0, 0, 0, 4'b0000);
        // Write and read of an empty channel together leaves it full.
        add(0, 1, 3, 2, 4'b1000, 1, 1,   0, 0, 0, 2, 4'b1000);
        add(0, 1, 3, 5, 4'b0000, 1, 0,   0, 0, 0, 2, 4'b1000);
        add(0, 0, 3, 0, 4'b1000, 1, 1,   0, 0, 0, 2, 4'b0000);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bus.in_valid = vecs[i].v;
            bus.s        = vecs[i].s;
            bus.w        = vecs[i].w;
            bus.rd       = vecs[i].rd;
            exp_q.push_back(vecs[i]);
        end
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.rd = 4'b0000;
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
